ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem.sv | 150 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_mem -- AHB-Lite word memory slave, programmable wait states
// Options  : AHB_SLAVE_MEM_ERR_RESP_EN enables two-cycle ERROR on out-of-range
// Revision : 1.0
// ============================================================================
module ahb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic        hready,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

`ifdef AHB_SLAVE_MEM_ERR_RESP_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LAST = 2'd2
  } state_t;
`endif

  state_t          state_q, state_d, accept_state;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   idx_q;
  logic [1:0]      lane_q;
  logic            write_q;
  logic [2:0]      size_q;
  logic [3:0]      be;
  logic            can_accept;
  logic            accept;
  logic            bad_addr;
  logic [31:0]     offset;

  logic [31:0]     mem [DEPTH_WORDS];

  assign offset = haddr - BASE_ADDR;

`ifdef AHB_SLAVE_MEM_ERR_RESP_EN
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  assign bad_addr   = (haddr < BASE_ADDR) || ({1'b0, offset} >= LIMIT);
  // ERR2 already shows hreadyout=1, so a pipelined address phase must not be lost
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2);
`else
  assign bad_addr   = 1'b0;
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_LAST);
`endif

  assign accept = can_accept && hsel && hready && htrans[1];

  always_comb begin
    accept_state = ST_LAST;
    if (WS != 4'd0) accept_state = ST_WAIT;
`ifdef AHB_SLAVE_MEM_ERR_RESP_EN
    if (bad_addr) accept_state = ST_ERR1;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = accept_state;
      ST_WAIT: if (cnt_q == 4'd1) state_d = ST_LAST;
      ST_LAST: state_d = accept ? accept_state : ST_IDLE;
`ifdef AHB_SLAVE_MEM_ERR_RESP_EN
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = accept ? accept_state : ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= WS;
        idx_q   <= offset[AW+1:2];
        lane_q  <= haddr[1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Little-endian lane enables; sizes above word behave as word
  always_comb begin
    be = 4'b1111;
    if (size_q == 3'b000) be = 4'b0001 << lane_q;
    else if (size_q == 3'b001) be = lane_q[1] ? 4'b1100 : 4'b0011;
  end

  // Reset forces IDLE, so an aborted transfer never reaches this write
  always_ff @(posedge hclk) begin
    if ((state_q == ST_LAST) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 2'b00;
    hrdata    = 32'd0;
    if (state_q == ST_WAIT) hreadyout = 1'b0;
    if ((state_q == ST_LAST) && !write_q) hrdata = mem[idx_q];
`ifdef AHB_SLAVE_MEM_ERR_RESP_EN
    if (state_q == ST_ERR1) hreadyout = 1'b0;
    if ((state_q == ST_ERR1) || (state_q == ST_ERR2)) hresp = 2'b01;
`endif
  end

  logic unused;
  assign unused = ^{hburst, htrans[0], offset, bad_addr};

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_slave_mem -- scoreboard bench for ahb_slave_mem (0 and 3 wait states)
// Revision : 1.0
// ============================================================================
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [1:0]  sel = 2'b00;
  logic [31:0] haddr = 32'd0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = 32'd0;

  logic        rdy0, rdy1;
  logic [1:0]  resp0, resp1;
  logic [31:0] rd0, rd1;

  always #5 hclk = ~hclk;

  // Each slave is alone on its bus, so its hreadyout is its global hready
  ahb_slave_mem #(.BASE_ADDR(32'h0), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(sel[0]), .hready(rdy0), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hreadyout(rdy0), .hresp(resp0), .hrdata(rd0)
  );

  ahb_slave_mem #(.BASE_ADDR(32'h0), .DEPTH_WORDS(256), .WAIT_STATES(3)) dut1 (
    .hclk(hclk), .hreset(hreset), .hsel(sel[1]), .hready(rdy1), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hreadyout(rdy1), .hresp(resp1), .hrdata(rd1)
  );

  typedef struct {
    string       name;
    int          dut;
    bit          chk;
    logic [31:0] data;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drives one pipelined address phase; returns once accepted, leaving hwdata for its data phase
  task automatic issue(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input string nm, input bit chk,
                       input logic [31:0] exp_data, input logic [1:0] exp_resp,
                       input int exp_waits, output int edges);
    exp_t e;
    logic r;
    sel    = 2'b01 << d;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    edges  = 0;
    do begin
      @(negedge hclk);
      r = (d == 0) ? rdy0 : rdy1;
      @(posedge hclk);
      edges++;
    end while (!r && edges < 50);
    if (!r) begin
      check({nm, "_accept_timeout"}, 32'(edges), 32'd0);
    end else begin
      e.name = nm; e.dut = d; e.chk = chk; e.data = exp_data;
      e.resp = exp_resp; e.waits = exp_waits;
      sb.push_back(e);
    end
    #1;
    sel    = 2'b00;
    htrans = 2'b00;
    hwrite = 1'b0;
    if (wr) hwdata = wd;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge hclk);
      n++;
    end
    check("drain_scoreboard", 32'(sb.size()), 32'd0);
    @(posedge hclk);
    #1;
  endtask

  int busy[2]  = '{0, 0};
  int waits[2] = '{0, 0};

  always @(negedge hclk) begin : monitor
    logic        r;
    logic [1:0]  rs;
    logic [31:0] rd;
    exp_t        e;
    for (int k = 0; k < 2; k++) begin
      r  = (k == 0) ? rdy0  : rdy1;
      rs = (k == 0) ? resp0 : resp1;
      rd = (k == 0) ? rd0   : rd1;
      if (!hreset) begin
        busy[k] = 0;
        check("reset_hreadyout", 32'(r), 32'd1);
        check("reset_hresp", 32'(rs), 32'd0);
        check("reset_hrdata", rd, 32'd0);
      end else if (busy[k] != 0) begin
        if (sb.size() == 0) begin
          check("scoreboard_underflow", 32'd0, 32'd1);
          busy[k] = 0;
        end else if (r) begin
          e = sb.pop_front();
          check({e.name, "_dut"}, 32'(k), 32'(e.dut));
          check({e.name, "_waits"}, 32'(waits[k]), 32'(e.waits));
          check({e.name, "_hresp"}, 32'(rs), 32'(e.resp));
          if (e.chk) check({e.name, "_hrdata"}, rd, e.data);
          busy[k] = 0;
        end else begin
          waits[k]++;
          check({sb[0].name, "_wait_hresp"}, 32'(rs), 32'(sb[0].resp));
          check({sb[0].name, "_wait_hrdata"}, rd, 32'd0);
        end
      end else begin
        check("idle_hreadyout", 32'(r), 32'd1);
        check("idle_hresp", 32'(rs), 32'd0);
        check("idle_hrdata", rd, 32'd0);
      end
      if (hreset && r && sel[k] && htrans[1]) begin
        busy[k]  = 1;
        waits[k] = 0;
      end
    end
    if (!hreset) sb.delete();
  end

  initial begin
    int edges;
    #1 hreset = 1'b0;
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b1;

    issue(0, 0, 32'h0, 3'd2, 32'h0, "first_rd", 0, 32'h0, 2'b00, 0, edges);
    check("first_accept_edges", 32'(edges), 32'd1);

    // back-to-back write then read of the same word
    issue(0, 1, 32'h0, 3'd2, 32'hDEADBEEF, "wr_w0", 1, 32'h0, 2'b00, 0, edges);
    issue(0, 0, 32'h0, 3'd2, 32'h0, "rd_w0_fwd", 1, 32'hDEADBEEF, 2'b00, 0, edges);

    issue(0, 1, 32'h4, 3'd2, 32'h11223344, "wr_w1", 1, 32'h0, 2'b00, 0, edges);
    issue(0, 1, 32'h6, 3'd0, 32'h00AA0000, "wr_byte6", 1, 32'h0, 2'b00, 0, edges);
    issue(0, 0, 32'h4, 3'd2, 32'h0, "rd_w1_byte", 1, 32'h11AA3344, 2'b00, 0, edges);

    issue(0, 1, 32'h2, 3'd1, 32'h55660000, "wr_half2", 1, 32'h0, 2'b00, 0, edges);
    issue(0, 0, 32'h0, 3'd2, 32'h0, "rd_w0_half", 1, 32'h5566BEEF, 2'b00, 0, edges);

    issue(0, 1, 32'hC, 3'd3, 32'h12345678, "wr_size3", 1, 32'h0, 2'b00, 0, edges);
    issue(0, 0, 32'hC, 3'd2, 32'h0, "rd_size3", 1, 32'h12345678, 2'b00, 0, edges);
    drain();

`ifdef AHB_SLAVE_MEM_ERR_RESP_EN
    issue(0, 0, 32'h400, 3'd2, 32'h0, "rd_oor_err", 1, 32'h0, 2'b01, 1, edges);
`else
    issue(0, 0, 32'h400, 3'd2, 32'h0, "rd_oor_wrap", 1, 32'h5566BEEF, 2'b00, 0, edges);
`endif
    drain();
    issue(0, 0, 32'h0, 3'd2, 32'h0, "rd_w0_after_oor", 1, 32'h5566BEEF, 2'b00, 0, edges);
    drain();

    // IDLE while selected, then NONSEQ while deselected: no storage effect
    sel = 2'b11; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h0; hwdata = 32'hFFFFFFFF;
    repeat (5) @(posedge hclk);
    #1 sel = 2'b00; htrans = 2'b10;
    repeat (5) @(posedge hclk);
    #1 htrans = 2'b00; hwrite = 1'b0;
    issue(0, 0, 32'h0, 3'd2, 32'h0, "rd_w0_after_idle", 1, 32'h5566BEEF, 2'b00, 0, edges);
    drain();

    issue(1, 1, 32'h8, 3'd2, 32'hCAFEF00D, "ws3_wr_w2", 1, 32'h0, 2'b00, 3, edges);
    issue(1, 0, 32'h8, 3'd2, 32'h0, "ws3_rd_w2", 1, 32'hCAFEF00D, 2'b00, 3, edges);
    drain();

    // reset lands in the middle of the wait states of a write
    issue(1, 1, 32'h8, 3'd2, 32'h0BAD0BAD, "ws3_wr_aborted", 1, 32'h0, 2'b00, 3, edges);
    @(posedge hclk);
    #1 hreset = 1'b0;
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b1;
    issue(1, 0, 32'h8, 3'd2, 32'h0, "ws3_rd_after_abort", 1, 32'hCAFEF00D, 2'b00, 3, edges);
    check("ws3_post_reset_accept_edges", 32'(edges), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
